// File: rtl/ex_mem_reg_ctrl_pkg.sv
// Shared types for the EX/MEM boundary: datapath words, write-back source select
// and the data-memory request controller states.
package ex_mem_reg_ctrl_pkg;

    localparam int WORD_BITS = 32;
    localparam int REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef enum logic [1:0] {
        RD_ALU = 2'd0,
        RD_MEM = 2'd1,
        RD_PC4 = 2'd2,
        RD_LUI = 2'd3
    } reg_dest_mux_selection;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } mem_ctrl_state_t;

    // A simultaneous load+store request resolves to the store alone: {ren, wen}.
    function automatic logic [1:0] store_wins(input logic ren, input logic wen);
        return {ren & ~wen, wen};
    endfunction

endpackage

// File: rtl/ex_mem_reg_ctrl_mem_req_fsm.sv
// Data-memory request controller: tracks the outstanding access, generates the
// cache strobes, the upstream stall and the stall-cycle counter.
module mem_req_fsm
    import ex_mem_reg_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            enable,
    input  logic            flush,
    input  logic            dren_in,
    input  logic            dwen_in,
    input  logic            halt_in,
    input  logic            dren_q,
    input  logic            dwen_q,
    input  logic            dhit,
    output logic            advance,
    output logic            mem_busy,
    output logic            dmemREN,
    output logic            dmemWEN,
    output logic [CNT_W-1:0] stall_cnt,
    output mem_ctrl_state_t state
);

    mem_ctrl_state_t state_r;
    mem_ctrl_state_t next_state_s;
    logic            take_new_s;
    logic            new_mem_op_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign mem_busy     = (state_r == WAIT) && !dhit;
    assign dmemREN      = (state_r == WAIT) && dren_q;
    assign dmemWEN      = (state_r == WAIT) && dwen_q;
    assign advance      = enable && !mem_busy && (state_r != HALTED);
    assign take_new_s   = advance && !flush;
    assign new_mem_op_s = dren_in || dwen_in;
    assign stall_cnt    = stall_cnt_r;
    assign state        = state_r;

    // Next-state selection; halt takes precedence over a co-issued memory op.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_new_s && halt_in) begin
                    next_state_s = HALTED;
                end else if (take_new_s && new_mem_op_s) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (!dhit) begin
                    next_state_s = WAIT;
                end else if (take_new_s && halt_in) begin
                    next_state_s = HALTED;
                end else if (take_new_s && new_mem_op_s) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HALTED:  next_state_s = HALTED;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (mem_busy && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ex_mem_reg_ctrl.sv
// EX/MEM pipeline register with the data-memory request controller attached;
// fields only move when the stage may advance, and halt freezes everything.
module ex_mem_reg_ctrl
    import ex_mem_reg_ctrl_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  enable_EX_MEM,
    input  logic                  flush_EX_MEM,
    input  logic                  dREN_ID_EX,
    input  logic                  dWEN_ID_EX,
    input  logic                  WEN_ID_EX,
    input  logic                  halt_ID_EX,
    input  reg_dest_mux_selection reg_dest_ID_EX,
    input  logic [WORD_W-1:0]     alu_result,
    input  logic [WORD_W-1:0]     rdat2_ID_EX,
    input  logic [REG_W-1:0]      wsel,
    input  logic                  dhit,
    input  logic [WORD_W-1:0]     dmemload,
    output logic                  dREN_EX_MEM,
    output logic                  dWEN_EX_MEM,
    output logic                  WEN_EX_MEM,
    output logic                  halt_EX_MEM,
    output reg_dest_mux_selection reg_dest_EX_MEM,
    output logic [WORD_W-1:0]     alu_result_EX_MEM,
    output logic [WORD_W-1:0]     store_data_EX_MEM,
    output logic [REG_W-1:0]      wsel_EX_MEM,
    output logic                  dmemREN,
    output logic                  dmemWEN,
    output logic [WORD_W-1:0]     dmemaddr,
    output logic [WORD_W-1:0]     dmemstore,
    output logic [WORD_W-1:0]     mem_rdata,
    output logic                  mem_busy,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic            advance_s;
    mem_ctrl_state_t state_s;
    logic [1:0]      rw_s;

    assign rw_s      = store_wins(dREN_ID_EX, dWEN_ID_EX);
    assign dmemaddr  = alu_result_EX_MEM;
    assign dmemstore = store_data_EX_MEM;
    assign mem_rdata = dmemload;

    mem_req_fsm #(.CNT_W(CNT_W)) u_fsm (
        .CLK       (CLK),
        .nRST      (nRST),
        .enable    (enable_EX_MEM),
        .flush     (flush_EX_MEM),
        .dren_in   (dREN_ID_EX),
        .dwen_in   (dWEN_ID_EX),
        .halt_in   (halt_ID_EX),
        .dren_q    (dREN_EX_MEM),
        .dwen_q    (dWEN_EX_MEM),
        .dhit      (dhit),
        .advance   (advance_s),
        .mem_busy  (mem_busy),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .stall_cnt (stall_cnt),
        .state     (state_s)
    );

    // Pipeline fields; a completed access not followed by an advance drops its request bits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dREN_EX_MEM       <= 1'b0;
            dWEN_EX_MEM       <= 1'b0;
            WEN_EX_MEM        <= 1'b0;
            halt_EX_MEM       <= 1'b0;
            reg_dest_EX_MEM   <= RD_ALU;
            alu_result_EX_MEM <= {WORD_W{1'b0}};
            store_data_EX_MEM <= {WORD_W{1'b0}};
            wsel_EX_MEM       <= {REG_W{1'b0}};
        end else if (advance_s) begin
            if (flush_EX_MEM) begin
                dREN_EX_MEM       <= 1'b0;
                dWEN_EX_MEM       <= 1'b0;
                WEN_EX_MEM        <= 1'b0;
                halt_EX_MEM       <= 1'b0;
                reg_dest_EX_MEM   <= RD_ALU;
                alu_result_EX_MEM <= {WORD_W{1'b0}};
                store_data_EX_MEM <= {WORD_W{1'b0}};
                wsel_EX_MEM       <= {REG_W{1'b0}};
            end else begin
                dREN_EX_MEM       <= rw_s[1];
                dWEN_EX_MEM       <= rw_s[0];
                WEN_EX_MEM        <= WEN_ID_EX;
                halt_EX_MEM       <= halt_ID_EX;
                reg_dest_EX_MEM   <= reg_dest_ID_EX;
                alu_result_EX_MEM <= alu_result;
                store_data_EX_MEM <= rdat2_ID_EX;
                wsel_EX_MEM       <= wsel;
            end
        end else if ((state_s == WAIT) && dhit) begin
            dREN_EX_MEM <= 1'b0;
            dWEN_EX_MEM <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg_ctrl.sv
// Bench for ex_mem_reg_ctrl: a transaction-level model of the stage (instruction
// held, access outstanding or not) checked every cycle, plus directed literal checks.
module tb_ex_mem_reg_ctrl;
    import ex_mem_reg_ctrl_pkg::*;

    localparam int W  = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic nRST;
    logic enable_EX_MEM, flush_EX_MEM, dREN_ID_EX, dWEN_ID_EX, WEN_ID_EX, halt_ID_EX, dhit;
    reg_dest_mux_selection reg_dest_ID_EX, reg_dest_EX_MEM;
    logic [W-1:0] alu_result, rdat2_ID_EX, dmemload;
    logic [RW-1:0] wsel, wsel_EX_MEM;
    logic dREN_EX_MEM, dWEN_EX_MEM, WEN_EX_MEM, halt_EX_MEM, dmemREN, dmemWEN, mem_busy;
    logic [W-1:0] alu_result_EX_MEM, store_data_EX_MEM, dmemaddr, dmemstore, mem_rdata;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    bit run_chk = 1'b0;

    // Model: the instruction held in the stage and whether its access is still pending.
    bit       m_ren, m_wen, m_wrf, m_halt, m_out;
    logic [1:0] m_rd;
    logic [W-1:0] m_alu, m_st;
    logic [RW-1:0] m_wsel;
    int       m_cnt;

    always #5 CLK = ~CLK;

    ex_mem_reg_ctrl #(.WORD_W(W), .REG_W(RW), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .enable_EX_MEM(enable_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
        .dREN_ID_EX(dREN_ID_EX), .dWEN_ID_EX(dWEN_ID_EX), .WEN_ID_EX(WEN_ID_EX),
        .halt_ID_EX(halt_ID_EX), .reg_dest_ID_EX(reg_dest_ID_EX), .alu_result(alu_result),
        .rdat2_ID_EX(rdat2_ID_EX), .wsel(wsel), .dhit(dhit), .dmemload(dmemload),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM), .WEN_EX_MEM(WEN_EX_MEM),
        .halt_EX_MEM(halt_EX_MEM), .reg_dest_EX_MEM(reg_dest_EX_MEM),
        .alu_result_EX_MEM(alu_result_EX_MEM), .store_data_EX_MEM(store_data_EX_MEM),
        .wsel_EX_MEM(wsel_EX_MEM), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ren = 1'b0; m_wen = 1'b0; m_wrf = 1'b0; m_halt = 1'b0; m_out = 1'b0;
        m_rd = 2'd0; m_alu = '0; m_st = '0; m_wsel = '0; m_cnt = 0;
    endtask

    // One clock: the model advances with the inputs present at the edge.
    task automatic step();
        bit busy, adv;
        if (dREN_ID_EX && dWEN_ID_EX) begin
            n_fail++;
            $display("FAIL illegal_input: got load+store expected at most one at %0t", $time);
        end
        @(posedge CLK);
        if (!nRST) begin
            model_clear();
        end else begin
            busy = m_out && !dhit;
            if (busy && m_cnt < CNT_MAX) m_cnt++;
            adv = enable_EX_MEM && !busy && !m_halt;
            if (adv && flush_EX_MEM) begin
                m_ren = 1'b0; m_wen = 1'b0; m_wrf = 1'b0; m_halt = 1'b0;
                m_rd = 2'd0; m_alu = '0; m_st = '0; m_wsel = '0; m_out = 1'b0;
            end else if (adv) begin
                m_ren = dREN_ID_EX; m_wen = dWEN_ID_EX; m_wrf = WEN_ID_EX; m_halt = halt_ID_EX;
                m_rd = reg_dest_ID_EX; m_alu = alu_result; m_st = rdat2_ID_EX; m_wsel = wsel;
                m_out = (m_ren || m_wen) && !m_halt;
            end else if (m_out && dhit) begin
                m_out = 1'b0; m_ren = 1'b0; m_wen = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        enable_EX_MEM = 1'b1; flush_EX_MEM = 1'b0; dREN_ID_EX = 1'b0; dWEN_ID_EX = 1'b0;
        WEN_ID_EX = 1'b0; halt_ID_EX = 1'b0; reg_dest_ID_EX = RD_ALU;
        alu_result = '0; rdat2_ID_EX = '0; wsel = '0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (run_chk) begin
            chk("m_dREN_EX_MEM", {31'd0, dREN_EX_MEM}, {31'd0, m_ren});
            chk("m_dWEN_EX_MEM", {31'd0, dWEN_EX_MEM}, {31'd0, m_wen});
            chk("m_WEN_EX_MEM", {31'd0, WEN_EX_MEM}, {31'd0, m_wrf});
            chk("m_halt_EX_MEM", {31'd0, halt_EX_MEM}, {31'd0, m_halt});
            chk("m_reg_dest", {30'd0, reg_dest_EX_MEM}, {30'd0, m_rd});
            chk("m_alu_result", alu_result_EX_MEM, m_alu);
            chk("m_store_data", store_data_EX_MEM, m_st);
            chk("m_wsel", {27'd0, wsel_EX_MEM}, {27'd0, m_wsel});
            chk("m_dmemREN", {31'd0, dmemREN}, {31'd0, m_out && m_ren});
            chk("m_dmemWEN", {31'd0, dmemWEN}, {31'd0, m_out && m_wen});
            chk("m_dmemaddr", dmemaddr, m_alu);
            chk("m_dmemstore", dmemstore, m_st);
            chk("m_mem_rdata", mem_rdata, dmemload);
            chk("m_mem_busy", {31'd0, mem_busy}, {31'd0, m_out && !dhit});
            chk("m_stall_cnt", {28'd0, stall_cnt}, m_cnt);
        end
    end

    initial begin
        nRST = 1'b0; dhit = 1'b0; dmemload = 32'h0000_0000;
        idle_inputs();
        enable_EX_MEM = 1'b0;
        model_clear();
        run_chk = 1'b1;
        step(); step();
        chk("rst_halt", {31'd0, halt_EX_MEM}, 32'd0);
        chk("rst_busy", {31'd0, mem_busy}, 32'd0);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
        nRST = 1'b1;
        step();

        // Load from 0x40, dhit arrives in the third waiting cycle.
        idle_inputs();
        dREN_ID_EX = 1'b1; alu_result = 32'h0000_0040; WEN_ID_EX = 1'b1;
        wsel = 5'd3; reg_dest_ID_EX = RD_MEM;
        step();
        idle_inputs();
        chk("ld_ren_c1", {31'd0, dmemREN}, 32'd1);
        chk("ld_addr_c1", dmemaddr, 32'h0000_0040);
        chk("ld_busy_c1", {31'd0, mem_busy}, 32'd1);
        step();
        chk("ld_busy_c2", {31'd0, mem_busy}, 32'd1);
        step();
        dhit = 1'b1; dmemload = 32'h1234_5678;
        #1;
        chk("ld_ren_c3", {31'd0, dmemREN}, 32'd1);
        chk("ld_busy_c3", {31'd0, mem_busy}, 32'd0);
        chk("ld_rdata", mem_rdata, 32'h1234_5678);
        step();
        dhit = 1'b0;
        chk("ld_ren_after", {31'd0, dmemREN}, 32'd0);
        chk("ld_cnt", {28'd0, stall_cnt}, 32'd2);

        // Store to 0x80 then load from 0x84 back to back.
        dWEN_ID_EX = 1'b1; alu_result = 32'h0000_0080; rdat2_ID_EX = 32'hDEAD_BEEF;
        step();
        chk("st_wen", {31'd0, dmemWEN}, 32'd1);
        chk("st_ren", {31'd0, dmemREN}, 32'd0);
        chk("st_addr", dmemaddr, 32'h0000_0080);
        chk("st_data", dmemstore, 32'hDEAD_BEEF);
        idle_inputs();
        dREN_ID_EX = 1'b1; alu_result = 32'h0000_0084; WEN_ID_EX = 1'b1; wsel = 5'd9;
        dhit = 1'b1;
        step();
        idle_inputs();
        chk("b2b_ren", {31'd0, dmemREN}, 32'd1);
        chk("b2b_wen", {31'd0, dmemWEN}, 32'd0);
        chk("b2b_addr", dmemaddr, 32'h0000_0084);
        step();
        dhit = 1'b0;

        // Flush held while an access is outstanding.
        dREN_ID_EX = 1'b1; alu_result = 32'h0000_0100; WEN_ID_EX = 1'b1; wsel = 5'd4;
        step();
        idle_inputs();
        flush_EX_MEM = 1'b1; dWEN_ID_EX = 1'b1; WEN_ID_EX = 1'b1; alu_result = 32'h0000_0200;
        step();
        chk("fl_ren_held", {31'd0, dmemREN}, 32'd1);
        chk("fl_addr_held", dmemaddr, 32'h0000_0100);
        dhit = 1'b1;
        step();
        dhit = 1'b0;
        chk("fl_bubble_wen", {31'd0, WEN_EX_MEM}, 32'd0);
        chk("fl_bubble_dwen", {31'd0, dWEN_EX_MEM}, 32'd0);
        chk("fl_bubble_alu", alu_result_EX_MEM, 32'h0000_0000);
        idle_inputs();

        // Long stall saturates the counter.
        dREN_ID_EX = 1'b1; alu_result = 32'h0000_0300;
        step();
        idle_inputs();
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", {28'd0, stall_cnt}, CNT_MAX);
        dhit = 1'b1;
        step();
        dhit = 1'b0;

        // Asynchronous reset while waiting.
        dREN_ID_EX = 1'b1; alu_result = 32'h0000_0400;
        step();
        idle_inputs();
        chk("ar_ren_before", {31'd0, dmemREN}, 32'd1);
        #3;
        nRST = 1'b0;
        model_clear();
        #1;
        chk("ar_ren_drop", {31'd0, dmemREN}, 32'd0);
        chk("ar_cnt_drop", {28'd0, stall_cnt}, 32'd0);
        step(); step();
        nRST = 1'b1;
        enable_EX_MEM = 1'b0;
        step();
        chk("ar_idle_busy", {31'd0, mem_busy}, 32'd0);
        enable_EX_MEM = 1'b1;

        // Halt freezes the stage.
        halt_ID_EX = 1'b1; WEN_ID_EX = 1'b1; wsel = 5'd31; alu_result = 32'h0000_0ACE;
        step();
        chk("h_halt", {31'd0, halt_EX_MEM}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            dREN_ID_EX = 1'b1; alu_result = 32'h1000_0000 + i; wsel = 5'(i);
            flush_EX_MEM = i[0];
            step();
        end
        chk("h_halt_hold", {31'd0, halt_EX_MEM}, 32'd1);
        chk("h_ren", {31'd0, dmemREN}, 32'd0);
        chk("h_wsel", {27'd0, wsel_EX_MEM}, 32'd31);
        chk("h_alu", alu_result_EX_MEM, 32'h0000_0ACE);

        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg_ctrl.md
Name: ex_mem_reg_ctrl

Overview:
EX/MEM pipeline register with an integrated data-memory request controller. It sits directly downstream of the ID/EX register and the EX-stage ALU.
- Latches EX results and control at the EX/MEM boundary.
- Drives dREN/dWEN toward the data cache and holds them until dhit.
- Raises a combinational stall to upstream stages while a memory access is outstanding.
- Latches a sticky halt.

Parameters:
WORD_W, 32, data/address width (matches word_t)
REG_W, 5, register-select width (matches regbits_t)
CNT_W, 32, width of the memory-stall performance counter

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
enable_EX_MEM  input  1  advance request from the hazard unit
flush_EX_MEM  input  1  bubble insert (clears control fields)
dREN_ID_EX  input  1  load in EX
dWEN_ID_EX  input  1  store in EX
WEN_ID_EX  input  1  register write-back enable
halt_ID_EX  input  1  halt instruction in EX
reg_dest_ID_EX  input  reg_dest_mux_selection  write-back source select
alu_result  input  WORD_W  ALU output (memory address / write-back value)
rdat2_ID_EX  input  WORD_W  store data
wsel  input  REG_W  resolved destination register
dhit  input  1  data cache hit/done
dmemload  input  WORD_W  data returned by the cache
dREN_EX_MEM, dWEN_EX_MEM, WEN_EX_MEM, halt_EX_MEM  output  1 each  registered control
reg_dest_EX_MEM  output  reg_dest_mux_selection  registered
alu_result_EX_MEM, store_data_EX_MEM  output  WORD_W  registered
wsel_EX_MEM  output  REG_W  registered
dmemREN, dmemWEN  output  1  cache request strobes
dmemaddr, dmemstore  output  WORD_W  cache address / store data
mem_rdata  output  WORD_W  dmemload passthrough, consumed by MEM/WB on the dhit cycle
mem_busy  output  1  stall request to hazard unit
stall_cnt  output  CNT_W  cycles spent with mem_busy=1

Behaviour:
Reset (nRST=0, async):
- All registered outputs 0, state IDLE, stall_cnt 0.

FSM states (mem_ctrl_state_t):
- IDLE: no access outstanding.
- WAIT: dREN_EX_MEM or dWEN_EX_MEM is set, awaiting dhit.
- HALTED: terminal.

Combinational outputs:
- mem_busy = (state==WAIT) && !dhit. Stall releases in the same cycle dhit arrives.
- dmemREN = (state==WAIT) && dREN_EX_MEM.
- dmemWEN = (state==WAIT) && dWEN_EX_MEM.
- dmemaddr = alu_result_EX_MEM; dmemstore = store_data_EX_MEM; mem_rdata = dmemload.

Latch condition: advance = enable_EX_MEM && !mem_busy && state!=HALTED.
- On advance without flush: all _EX_MEM fields load from their inputs next edge (1-cycle latency).
- On advance with flush_EX_MEM=1: dREN/dWEN/WEN/halt fields load 0, data fields load 0.
- flush takes priority over new data.
- flush is honoured only when mem_busy=0. The outstanding access always completes, and the hazard unit holds flush.

Transitions:
- IDLE to WAIT: advance with unflushed dREN_ID_EX or dWEN_ID_EX.
- IDLE to HALTED: advance with unflushed halt_ID_EX.
- Otherwise IDLE stays IDLE.
- In WAIT without dhit: hold all fields and requests; enable_EX_MEM is ignored.
- In WAIT with dhit and advance into a new memory op: stay in WAIT with the new request. Strobes deassert for at most 0 cycles; a new address is presented next cycle.
- In WAIT with dhit and advance into a halt: go to HALTED.
- In WAIT with dhit and otherwise: go to IDLE. If not advancing, the request fields clear so the same access is not reissued.

HALTED:
- Registers frozen, dmemREN/dmemWEN=0, halt_EX_MEM=1 until reset.

Illegal input:
- dREN_ID_EX && dWEN_ID_EX both 1 is illegal. The store wins and only dWEN is latched; the bench asserts this never occurs.

stall_cnt:
- Increments each cycle mem_busy=1.
- Saturates at all-ones, never wraps.

Reset mid-access:
- Strobes drop immediately (asynchronous); state returns to IDLE.

Decomposition:
- Add mem_ctrl_state_t (IDLE, WAIT, HALTED) to data_path_muxs_pkg.
- Reuse word_t/regbits_t from cpu_types_pkg and reg_dest_mux_selection from data_path_muxs_pkg.
- Add ex_mem_reg_if.vh with an ex_mem_reg modport, mirroring the ID/EX interface style.
- One natural sub-module, mem_req_fsm: state register, mem_busy, strobes and stall_cnt.
- Pipeline field registers stay in the top module.

Test Plan:
- Reset then idle: nRST low 2 cycles → all outputs 0, mem_busy=0, stall_cnt=0.
- Load: dREN_ID_EX=1, alu_result=0x0000_0040, enable=1, dhit after 3 cycles → dmemREN=1 with dmemaddr=0x40 for 3 cycles, mem_busy high 2 cycles then low on dhit cycle, mem_rdata=dmemload, stall_cnt=2, dmemREN=0 next cycle.
- Back-to-back store then load: store 0xDEAD_BEEF to 0x80 (dhit after 1 cycle), then load from 0x84 → dmemWEN then dmemREN with no cycle of both high, addresses 0x80 then 0x84.
- Flush during busy: flush_EX_MEM=1 while in WAIT → access completes at dhit; the bubble latches afterward with all control fields 0.
- Halt: halt_ID_EX=1 advanced → halt_EX_MEM=1 next cycle; further enable/inputs ignored for 10 cycles; strobes stay 0.
- Async reset mid-WAIT: nRST falls between edges → dmemREN drops immediately; state IDLE after release.
